player_mover: RTL and testbench



---
 rtl/bomber_pkg.sv | 24 ++
 rtl/player_mover_if.sv | 34 +++
 rtl/axis_step.sv | 35 +++
 rtl/player_mover.sv | 173 +++++++++++++++++
 tb/tb_player_mover.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/bomber_pkg.sv
// Shared definitions for the Bomberman player position logic: key bit positions,
// coordinate type, mover FSM states and default video timing.
package bomber_pkg;

  // Each player's key nibble is active-low {left, up, down, right}
  localparam int KEY_RIGHT = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_LEFT  = 3;

  localparam int COORD_W_DEF = 11;
  localparam int HACTIVE_DEF = 800;
  localparam int VACTIVE_DEF = 600;

  typedef logic signed [COORD_W_DEF-1:0] coord_t;

  typedef enum logic [1:0] {
    LOCK   = 2'd0,
    COUNT  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/player_mover_if.sv
// Frame-sync, key and position bundle between the input block, the mover and the renderer.
// With PLAYER_SPEED_EN defined the bundle also carries a 2-bit speed code per player.
interface player_mover_if #(
  parameter int N_PLAYERS = 2,
  parameter int COORD_W   = 11
);
  logic                         SOF;
  logic                         EOF;
  logic [4*N_PLAYERS-1:0]       keys;
  logic [N_PLAYERS-1:0]         alive;
`ifdef PLAYER_SPEED_EN
  logic [2*N_PLAYERS-1:0]       speed;
`endif
  logic [N_PLAYERS*COORD_W-1:0] pos_x;
  logic [N_PLAYERS*COORD_W-1:0] pos_y;
  logic [N_PLAYERS-1:0]         moved;
  logic                         frame_done;

  modport master (
    output SOF, EOF, keys, alive,
`ifdef PLAYER_SPEED_EN
    output speed,
`endif
    input  pos_x, pos_y, moved, frame_done
  );

  modport slave (
    input  SOF, EOF, keys, alive,
`ifdef PLAYER_SPEED_EN
    input  speed,
`endif
    output pos_x, pos_y, moved, frame_done
  );
endinterface

// File: rtl/axis_step.sv
// One coordinate axis: applies +step/-step from two buttons and saturates to [0, max_pos].
module axis_step #(
  parameter int COORD_W = 11
) (
  input  logic signed [COORD_W-1:0] pos,
  input  logic                      plus,
  input  logic                      minus,
  input  logic signed [COORD_W-1:0] step,
  input  logic signed [COORD_W-1:0] max_pos,
  output logic signed [COORD_W-1:0] new_pos,
  output logic                      changed
);
  logic signed [COORD_W:0] sum;

  // Sum is one bit wider so the edge cases never wrap before saturation
  function automatic logic signed [COORD_W-1:0] sat(input logic signed [COORD_W:0] v,
                                                    input logic signed [COORD_W-1:0] hi);
    if (v[COORD_W])
      return '0;
    else if (v > $signed({hi[COORD_W-1], hi}))
      return hi;
    else
      return v[COORD_W-1:0];
  endfunction

  always_comb begin
    sum = $signed({pos[COORD_W-1], pos});
    if (plus && !minus)
      sum = sum + $signed({step[COORD_W-1], step});
    else if (minus && !plus)
      sum = sum - $signed({step[COORD_W-1], step});
    new_pos = sat(sum, max_pos);
    changed = (new_pos != pos);
  end
endmodule

// File: rtl/player_mover.sv
// Per-frame position controller for up to four players; moves each sprite once per vertical
// blanking, one player per cycle. Define PLAYER_SPEED_EN to enable per-player speed codes.
module player_mover
  import bomber_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int COORD_W   = 11,
  parameter int HACTIVE   = HACTIVE_DEF,
  parameter int VACTIVE   = VACTIVE_DEF,
  parameter int SPRITE_W  = 32,
  parameter int SPRITE_H  = 32,
  parameter int STEP      = 1,
  parameter int TICK_DLY  = 3000,
  parameter int START_X   = 32,
  parameter int START_Y   = 32
) (
  input logic           clk,
  input logic           reset,
  player_mover_if.slave bus
);
  localparam int XMAX  = HACTIVE - SPRITE_W;
  localparam int YMAX  = VACTIVE - SPRITE_H;
  localparam int CNT_W = $clog2(TICK_DLY + 1);

  typedef logic signed [COORD_W-1:0] crd_t;

  localparam crd_t             XMAX_C   = crd_t'(XMAX);
  localparam crd_t             YMAX_C   = crd_t'(YMAX);
  localparam logic [1:0]       LAST     = 2'(N_PLAYERS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DLY - 1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [1:0]           idx, idx_n;
  logic                 upd, done_n;
  crd_t                 px [N_PLAYERS];
  crd_t                 py [N_PLAYERS];
  crd_t                 cur_x, cur_y, new_x, new_y, step;
  logic [3:0]           cur_key;
  logic                 cur_alive, chg_x, chg_y;
  logic [N_PLAYERS-1:0] moved_q;
  logic                 frame_done_q;

  // Players start in the four corners, inset by START_X/START_Y
  function automatic crd_t reset_x(input int i);
    return crd_t'((i == 1 || i == 2) ? XMAX - START_X : START_X);
  endfunction

  function automatic crd_t reset_y(input int i);
    return crd_t'((i == 1 || i == 3) ? YMAX - START_Y : START_Y);
  endfunction

  always_comb begin
    cur_x     = '0;
    cur_y     = '0;
    cur_key   = '1;
    cur_alive = 1'b0;
    step      = crd_t'(STEP);
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (idx == 2'(i)) begin
        cur_x     = px[i];
        cur_y     = py[i];
        cur_key   = bus.keys[4*i +: 4];
        cur_alive = bus.alive[i];
`ifdef PLAYER_SPEED_EN
        step      = crd_t'(STEP) << bus.speed[2*i +: 2];
`endif
      end
    end
  end

  axis_step #(.COORD_W(COORD_W)) u_axis_x (
    .pos(cur_x), .plus(~cur_key[KEY_RIGHT]), .minus(~cur_key[KEY_LEFT]),
    .step(step), .max_pos(XMAX_C), .new_pos(new_x), .changed(chg_x)
  );

  axis_step #(.COORD_W(COORD_W)) u_axis_y (
    .pos(cur_y), .plus(~cur_key[KEY_DOWN]), .minus(~cur_key[KEY_UP]),
    .step(step), .max_pos(YMAX_C), .new_pos(new_y), .changed(chg_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOCK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // SOF has priority everywhere: it aborts a frame in progress and wins over a same-cycle EOF
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    upd     = 1'b0;
    done_n  = 1'b0;
    case (state)
      LOCK: begin
        if (bus.EOF && !bus.SOF) begin
          state_n = COUNT;
          cnt_n   = '0;
        end
      end
      COUNT: begin
        if (bus.SOF) begin
          state_n = LOCK;
        end else if (cnt == CNT_LAST) begin
          state_n = UPDATE;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      UPDATE: begin
        if (bus.SOF) begin
          state_n = LOCK;
        end else begin
          upd = 1'b1;
          if (idx == LAST) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.SOF)
          state_n = LOCK;
      end
      default: state_n = LOCK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        px[i] <= reset_x(i);
        py[i] <= reset_y(i);
      end
      moved_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      moved_q      <= '0;
      frame_done_q <= done_n;
      if (upd && cur_alive && (chg_x || chg_y)) begin
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (idx == 2'(i)) begin
            px[i]      <= new_x;
            py[i]      <= new_y;
            moved_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bus.pos_x = '0;
    bus.pos_y = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      bus.pos_x[i*COORD_W +: COORD_W] = px[i];
      bus.pos_y[i*COORD_W +: COORD_W] = py[i];
    end
  end

  assign bus.moved      = moved_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: a default-timing instance and a short-tick instance near the walls.
module tb_player_mover;
  import bomber_pkg::*;

  localparam int N     = 2;
  localparam int CW    = 11;
  localparam int TICK0 = 3000;
  localparam int TICK1 = 4;
  localparam int XMAX  = 768;
  localparam int YMAX  = 568;

  typedef struct {
    int         x0, y0, x1, y1;
    logic [1:0] mv;
    bit         done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           sof [2];
  logic           eof [2];
  logic [4*N-1:0] keys [2];
  logic [N-1:0]   alive [2];
  logic [2*N-1:0] speed [2];
  logic [N*CW-1:0] ox [2];
  logic [N*CW-1:0] oy [2];
  logic [N-1:0]   omv [2];
  logic           ofd [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   fr    = 0;
  int   mx [2][2];
  int   my [2][2];
  exp_t sb [$];

  player_mover_if #(.N_PLAYERS(N), .COORD_W(CW)) bus0 ();
  player_mover_if #(.N_PLAYERS(N), .COORD_W(CW)) bus1 ();

  assign bus0.SOF = sof[0];
  assign bus0.EOF = eof[0];
  assign bus0.keys = keys[0];
  assign bus0.alive = alive[0];
  assign bus1.SOF = sof[1];
  assign bus1.EOF = eof[1];
  assign bus1.keys = keys[1];
  assign bus1.alive = alive[1];
`ifdef PLAYER_SPEED_EN
  assign bus0.speed = speed[0];
  assign bus1.speed = speed[1];
`endif
  assign ox[0] = bus0.pos_x;
  assign oy[0] = bus0.pos_y;
  assign omv[0] = bus0.moved;
  assign ofd[0] = bus0.frame_done;
  assign ox[1] = bus1.pos_x;
  assign oy[1] = bus1.pos_y;
  assign omv[1] = bus1.moved;
  assign ofd[1] = bus1.frame_done;

  player_mover #(.N_PLAYERS(N), .COORD_W(CW), .TICK_DLY(TICK0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  player_mover #(.N_PLAYERS(N), .COORD_W(CW), .TICK_DLY(TICK1), .START_X(766), .START_Y(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int mstep(input int p, input bit plus, input bit minus, input int s, input int hi);
    int n = p;
    if (plus && !minus) n = p + s;
    else if (minus && !plus) n = p - s;
    if (n < 0) n = 0;
    if (n > hi) n = hi;
    return n;
  endfunction

  task automatic push_frame(input int d, input bit abort);
    exp_t       e;
    int         nx, ny, s;
    logic [3:0] k;
    e.mv   = '0;
    e.done = !abort;
    for (int p = 0; p < 2; p++) begin
      k = keys[d][4*p +: 4];
      s = 1;
`ifdef PLAYER_SPEED_EN
      s = 1 << speed[d][2*p +: 2];
`endif
      nx = mx[d][p];
      ny = my[d][p];
      if (!abort && alive[d][p]) begin
        nx = mstep(nx, !k[0], !k[3], s, XMAX);
        ny = mstep(ny, !k[1], !k[2], s, YMAX);
      end
      if (nx != mx[d][p] || ny != my[d][p]) e.mv[p] = 1'b1;
      mx[d][p] = nx;
      my[d][p] = ny;
    end
    e.x0 = mx[d][0];
    e.y0 = my[d][0];
    e.x1 = mx[d][1];
    e.y1 = my[d][1];
    sb.push_back(e);
  endtask

  task automatic run_frame(input int d, input int abort_at);
    exp_t       e;
    int         lat, mv0c, fdcnt, tick;
    logic [1:0] mvacc;
    tick  = (d == 0) ? TICK0 : TICK1;
    lat   = -1;
    mv0c  = -1;
    fdcnt = 0;
    mvacc = '0;
    fr++;
    @(negedge clk); eof[d] = 1'b1;
    @(negedge clk); eof[d] = 1'b0;
    for (int c = 1; c <= tick + 20; c++) begin
      sof[d] = (c == abort_at);
      @(negedge clk);
      mvacc = mvacc | omv[d];
      if (omv[d][0] && mv0c < 0) mv0c = c;
      if (ofd[d]) begin
        fdcnt++;
        if (lat < 0) lat = c;
      end
    end
    sof[d] = 1'b1;
    @(negedge clk); sof[d] = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL f%0d scoreboard: observed empty expected entry", fr);
    end else begin
      e = sb.pop_front();
      chk($sformatf("f%0d d%0d p0x", fr, d), ox[d][CW-1:0],      e.x0);
      chk($sformatf("f%0d d%0d p0y", fr, d), oy[d][CW-1:0],      e.y0);
      chk($sformatf("f%0d d%0d p1x", fr, d), ox[d][2*CW-1:CW],   e.x1);
      chk($sformatf("f%0d d%0d p1y", fr, d), oy[d][2*CW-1:CW],   e.y1);
      chk($sformatf("f%0d d%0d moved", fr, d), mvacc,            e.mv);
      chk($sformatf("f%0d d%0d done_cnt", fr, d), fdcnt,         e.done ? 1 : 0);
      chk($sformatf("f%0d d%0d done_lat", fr, d), lat,           e.done ? tick + N : -1);
      chk($sformatf("f%0d d%0d mv0_lat", fr, d), mv0c,           e.mv[0] ? tick + 1 : -1);
    end
  endtask

  initial begin
    int fdseen;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sof[d] = 1'b0; eof[d] = 1'b0; keys[d] = '1; alive[d] = '1; speed[d] = '0;
    end
    mx[0][0] = 32;  my[0][0] = 32;  mx[0][1] = 736; my[0][1] = 536;
    mx[1][0] = 766; my[1][0] = 1;   mx[1][1] = 2;   my[1][1] = 567;
    repeat (3) @(negedge clk);
    chk("rst p0x", ox[0][CW-1:0], 32);
    chk("rst p0y", oy[0][CW-1:0], 32);
    chk("rst p1x", ox[0][2*CW-1:CW], 736);
    chk("rst p1y", oy[0][2*CW-1:CW], 536);
    chk("rst moved", omv[0], 0);
    chk("rst done", ofd[0], 0);
    chk("rst d1 p1x", ox[1][2*CW-1:CW], 2);
    reset = 1'b0;
    @(negedge clk);

    // Player 0 steps right
    keys[0] = {4'hF, 4'b1110};
    push_frame(0, 1'b0);
    run_frame(0, 0);
    repeat (50) @(negedge clk);
    chk("idle p0x", ox[0][CW-1:0], mx[0][0]);

    // Player 1 left+down, then left+right cancels
    keys[0] = {4'b0101, 4'hF};
    push_frame(0, 1'b0);
    run_frame(0, 0);
    keys[0] = {4'b0110, 4'hF};
    push_frame(0, 1'b0);
    run_frame(0, 0);

    // SOF mid-count aborts, next frame updates normally
    keys[0] = {4'hF, 4'b1110};
    push_frame(0, 1'b1);
    run_frame(0, 1500);
    push_frame(0, 1'b0);
    run_frame(0, 0);

    // SOF with EOF in the same cycle keeps the mover locked
    @(negedge clk); sof[1] = 1'b1; eof[1] = 1'b1;
    @(negedge clk); sof[1] = 1'b0; eof[1] = 1'b0;
    fdseen = 0;
    for (int c = 0; c < TICK1 + 10; c++) begin
      @(negedge clk);
      if (ofd[1] || omv[1] != 0) fdseen++;
    end
    chk("sof+eof no frame", fdseen, 0);

    // Walls: P0 right+up from (766,1), P1 left from (2,567)
    keys[1] = {4'b0111, 4'b1010};
    for (int f = 0; f < 3; f++) begin
      push_frame(1, 1'b0);
      run_frame(1, 0);
    end

    // Dead player 0 ignores keys, player 1 moves up
    alive[1] = 2'b10;
    keys[1]  = {4'b1011, 4'b0111};
    push_frame(1, 1'b0);
    run_frame(1, 0);
    alive[1] = 2'b11;

`ifdef PLAYER_SPEED_EN
    keys[1]  = {4'hF, 4'b0111};
    speed[1] = 4'b0010;
    push_frame(1, 1'b0);
    run_frame(1, 0);
    keys[1]  = {4'hF, 4'b1110};
    speed[1] = 4'b0011;
    push_frame(1, 1'b0);
    run_frame(1, 0);
`endif

    chk("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
